// File: rtl/adder_arbiter_if.sv
// Request/response bundle between R requesters, the adder arbiter and the result consumer.
interface adder_arbiter_if #(
  parameter int N    = 4,
  parameter int R    = 4,
  parameter int ID_W = $clog2(R)
);
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_x;
  logic [R*N-1:0] req_y;
  logic [R-1:0]   req_cin;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [N-1:0]   rsp_sum;
  logic           rsp_cout;
  logic [ID_W-1:0] rsp_id;

  modport master (
    output req_valid, req_x, req_y, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

  modport slave (
    input  req_valid, req_x, req_y, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );
endinterface

// File: rtl/adder_arbiter.sv
// Shares one adder_n_bit among R requesters: accept -> rsp_valid in 2 cycles, HOLD stalls on rsp_ready.
// Grant is fixed-priority by default; define ADDER_ARB_ROUND_ROBIN_EN for round-robin.

// Plain ripple-style N-bit adder, purely combinational.
module adder_n_bit #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);
  assign {c_out, sum} = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c_in};
endmodule

module adder_arbiter #(
  parameter int N    = 4,
  parameter int R    = 4,
  parameter int ID_W = $clog2(R)
) (
  input  logic          clk,
  input  logic          rst_n,
  adder_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t          state;
  logic [N-1:0]    op_x;
  logic [N-1:0]    op_y;
  logic            op_cin;
  logic [ID_W-1:0] op_id;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] gnt_idx;
  logic [N-1:0]    sum;
  logic            c_out;
  logic            accept;
  logic            rsp_valid;
  logic [N-1:0]    rsp_sum;
  logic            rsp_cout;
  logic [ID_W-1:0] rsp_id;

  adder_n_bit #(.N(N)) u_adder (
    .x    (op_x),
    .y    (op_y),
    .c_in (op_cin),
    .sum  (sum),
    .c_out(c_out)
  );

  // gnt_idx only matters when some request is valid; last_grant is the don't-care default.
  always_comb begin
    gnt_idx = last_grant;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
    for (int k = R; k >= 1; k--) begin
      int cand;
      cand = (int'(last_grant) + k) % R;
      if (bus.req_valid[cand]) gnt_idx = ID_W'(cand);
    end
`else
    for (int i = R - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) gnt_idx = ID_W'(i);
    end
`endif
  end

  assign accept        = rst_n && (state == IDLE) && (|bus.req_valid);
  assign bus.req_ready = accept ? (R'(1) << gnt_idx) : '0;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_sum   = rsp_sum;
  assign bus.rsp_cout  = rsp_cout;
  assign bus.rsp_id    = rsp_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_x       <= '0;
      op_y       <= '0;
      op_cin     <= 1'b0;
      op_id      <= '0;
      last_grant <= ID_W'(R - 1);
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_id     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_x       <= bus.req_x[gnt_idx*N +: N];
            op_y       <= bus.req_y[gnt_idx*N +: N];
            op_cin     <= bus.req_cin[gnt_idx];
            op_id      <= gnt_idx;
            last_grant <= gnt_idx;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum   <= sum;
          rsp_cout  <= c_out;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed-vector bench for adder_arbiter (N=4, R=4) with a response scoreboard.
module tb_adder_arbiter;
  typedef struct {
    logic [1:0] id;
    logic [3:0] sum;
    logic       cout;
  } exp_t;

  logic clk;
  logic rst_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  exp_t exp_q[$];

  // Single-request vectors: id, x, y, cin -> hand-computed sum, cout.
  int v_id   [5] = '{2, 1, 3, 0, 0};
  int v_x    [5] = '{4'h7, 4'hF, 4'hF, 4'hA, 4'h3};
  int v_y    [5] = '{4'h5, 4'h1, 4'hF, 4'h6, 4'h4};
  int v_cin  [5] = '{1, 0, 1, 0, 0};
  int v_sum  [5] = '{4'hD, 4'h0, 4'hF, 4'h0, 4'h7};
  int v_cout [5] = '{0, 1, 1, 1, 0};

  // Contention operands: requester i offers x=8+i, y=7, cin=i[0].
  int a_sum  [4] = '{4'hF, 4'h1, 4'h1, 4'h3};
  int a_cout [4] = '{0, 1, 1, 1};
  int arb_ids[5];

  adder_arbiter_if #(.N(4), .R(4)) bus ();

  adder_arbiter #(.N(4), .R(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic push_exp(input int id, input int s, input int c);
    exp_t e;
    e.id   = 2'(id);
    e.sum  = 4'(s);
    e.cout = 1'(c);
    exp_q.push_back(e);
  endtask

  task automatic wait_grant(output logic [3:0] g, output int waited);
    g = '0;
    waited = 0;
    while (waited < 20) begin
      @(negedge clk);
      waited++;
      if (bus.req_ready != '0) begin
        g = bus.req_ready;
        break;
      end
    end
  endtask

  task automatic set_req(input int id, input int x, input int y, input int cin);
    bus.req_x[id*4 +: 4] = 4'(x);
    bus.req_y[id*4 +: 4] = 4'(y);
    bus.req_cin[id]      = 1'(cin);
    bus.req_valid[id]    = 1'b1;
  endtask

  task automatic do_vec(input int id, input int x, input int y, input int cin,
                        input int es, input int ec);
    logic [3:0] g;
    int w;
    set_req(id, x, y, cin);
    wait_grant(g, w);
    check("vec_grant", 32'(g), 32'(4'b0001 << id));
    push_exp(id, es, ec);
    @(posedge clk); #2;
    bus.req_valid[id] = 1'b0;
    @(negedge clk);
    check("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("exec_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    @(posedge clk); #2;
  endtask

  // Scoreboard monitor: compare each handshaked response against the head of the queue.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp_id", 32'(bus.rsp_id), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_id",   32'(bus.rsp_id),   32'(e.id));
        check("rsp_sum",  32'(bus.rsp_sum),  32'(e.sum));
        check("rsp_cout", 32'(bus.rsp_cout), 32'(e.cout));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end

  initial begin
    logic [3:0] g;
    int w;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
    arb_ids = '{0, 1, 2, 3, 0};
`else
    arb_ids = '{0, 0, 0, 0, 0};
`endif
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b1;
    #3;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_sum",   32'(bus.rsp_sum),   32'd0);
    check("rst_rsp_cout",  32'(bus.rsp_cout),  32'd0);
    check("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      do_vec(v_id[i], v_x[i], v_y[i], v_cin[i], v_sum[i], v_cout[i]);

    // Back-pressure: response held for 5 cycles while requester 3 waits.
    bus.rsp_ready = 1'b0;
    set_req(1, 4'h2, 4'h3, 0);
    wait_grant(g, w);
    check("bp_grant", 32'(g), 32'b0010);
    push_exp(1, 4'h5, 0);
    @(posedge clk); #2;
    bus.req_valid[1] = 1'b0;
    set_req(3, 4'h1, 4'h1, 1);
    @(negedge clk);
    check("bp_exec_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_sum",   32'(bus.rsp_sum),   32'h5);
      check("bp_rsp_cout",  32'(bus.rsp_cout),  32'd0);
      check("bp_rsp_id",    32'(bus.rsp_id),    32'd1);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #2;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    wait_grant(g, w);
    check("bp_next_grant", 32'(g), 32'b1000);
    check("bp_next_delay", 32'(w), 32'd1);
    push_exp(3, 4'h3, 0);
    @(posedge clk); #2;
    bus.req_valid[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #2;

    // Reset while a result for 4+5 sits in HOLD; it must be discarded.
    bus.rsp_ready = 1'b0;
    set_req(0, 4'h4, 4'h5, 0);
    wait_grant(g, w);
    check("rst_hold_grant", 32'(g), 32'b0001);
    @(posedge clk); #2;
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_rsp_sum", 32'(bus.rsp_sum), 32'h9);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_rsp_sum",   32'(bus.rsp_sum),   32'd0);
    check("mid_rst_rsp_cout",  32'(bus.rsp_cout),  32'd0);
    check("mid_rst_rsp_id",    32'(bus.rsp_id),    32'd0);
    for (int i = 0; i < 4; i++) set_req(i, 8 + i, 7, i % 2);
    #1;
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Contention: all four valid continuously.
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, w);
      check("arb_grant", 32'(g), 32'(4'b0001 << arb_ids[k]));
      if (k > 0) check("arb_spacing", 32'(w), 32'd3);
      push_exp(arb_ids[k], a_sum[arb_ids[k]], a_cout[arb_ids[k]]);
    end
    @(posedge clk); #2;
    bus.req_valid[0] = 1'b0;
    wait_grant(g, w);
    check("arb_drop0_grant", 32'(g), 32'b0010);
    check("arb_drop0_spacing", 32'(w), 32'd3);
    push_exp(1, a_sum[1], a_cout[1]);
    @(posedge clk); #2;
    bus.req_valid = '0;
    repeat (6) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares a single `adder_n_bit` instance between `R` independent requesters. Each requester offers an operand pair plus carry-in over a valid/ready handshake. The arbiter grants one requester at a time and registers the operands into the shared adder. It returns the sum, carry-out and requester id over a response valid/ready handshake. The block sits between the requesting datapath units and the adder.

## Interface
- `N`, default 4: adder operand width, passed to the internal `adder_n_bit`.
- `R`, default 4: number of requesters, R ≥ 2.
- `ID_W`, default `$clog2(R)`: requester id width.

- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  R  bit i: requester i has an operation pending.
- `req_ready`  out  R  bit i: requester i accepted this cycle; at most one bit set.
- `req_x`  in  R*N  requester i operand x at [i*N +: N].
- `req_y`  in  R*N  requester i operand y at [i*N +: N].
- `req_cin`  in  R  bit i: requester i carry-in.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_sum`  out  N  registered sum.
- `rsp_cout`  out  1  registered carry-out.
- `rsp_id`  out  ID_W  index of the requester that produced the response.

## Operation
- One `adder_n_bit #(N)` instance, fed from operand registers `op_x`, `op_y`, `op_cin`.
- FSM states: IDLE, EXEC, HOLD. Reset state is IDLE.
- IDLE:
  - If any `req_valid` bit is set, select grant g and assert `req_ready[g]` combinationally in the same cycle.
  - On that clock edge, capture `req_x[g]`, `req_y[g]`, `req_cin[g]` and g, then go to EXEC.
  - With no valid request, stay in IDLE and keep `req_ready` = 0.
- EXEC:
  - The adder evaluates the operand registers.
  - At the end of the cycle, register `sum` to `rsp_sum`, `c_out` to `rsp_cout` and g to `rsp_id`, then go to HOLD.
- HOLD:
  - `rsp_valid` = 1.
  - `rsp_sum`, `rsp_cout` and `rsp_id` stay stable until `rsp_ready` = 1.
  - On `rsp_ready` = 1, go to IDLE.
  - No request is accepted in HOLD.
- `req_ready` is 0 in EXEC and HOLD.
- Requester protocol: a requester holds `req_valid` and its operands stable until it sees `req_ready`. A `req_valid` dropped before grant is simply not considered.
- Arithmetic is modulo 2^N. `rsp_cout` is bit N of x + y + cin, with no sign interpretation.
- Grant selection is defined by the configuration macro below. Both modes update `last_grant` to g on every accept.

## Timing
- Reset, asserted asynchronously at any time, including mid-EXEC or HOLD:
  - State is IDLE.
  - `rsp_valid` = 0, `rsp_sum` = 0, `rsp_cout` = 0, `rsp_id` = 0, `req_ready` = 0.
  - `last_grant` = R-1, so requester 0 has first priority.
  - Operand registers = 0.
  - Any in-flight result is discarded.
- Latency: accept edge at cycle t, then `rsp_valid` = 1 in cycle t+2.
- Throughput with `rsp_ready` tied to 1: one operation per 3 cycles. Accept in IDLE, EXEC, HOLD with handshake, back to IDLE.
- Response back-pressure: HOLD persists indefinitely. All other requesters wait with `req_valid` held.
- Simultaneous events: all R requesters valid in the same cycle results in exactly one `req_ready` bit. The others retry in later IDLE cycles.
- A single requester valid continuously is served once every 3 cycles regardless of mode.

## Configuration
- `ADDER_ARB_ROUND_ROBIN_EN` defined: round-robin.
  - g is the first valid index searching from `(last_grant+1) mod R` upward, wrapping around.
  - Every continuously valid requester is served within R grants.
- Not defined: fixed priority.
  - g is the lowest valid index.
  - `last_grant` is still maintained but ignored.
  - Higher indices may starve.

## Test plan
All scenarios use N=4, R=4.

- **Reset:** assert `rst_n`=0 in HOLD with `rsp_sum`=0x9 → all outputs 0 immediately; after release, first grant goes to requester 0 when all are valid.
- **Single request:** req 2 only, x=0x7, y=0x5, cin=1, `rsp_ready`=1 → `req_ready`=4'b0100 at t; at t+2 `rsp_valid`=1, `rsp_sum`=0xD, `rsp_cout`=0, `rsp_id`=2.
- **Overflow:** x=0xF, y=0x1, cin=0 → `rsp_sum`=0x0, `rsp_cout`=1; x=0xF, y=0xF, cin=1 → `rsp_sum`=0xF, `rsp_cout`=1.
- **Back-pressure:** `rsp_ready`=0 for 5 cycles in HOLD → response outputs stable, `req_ready`=0 throughout; release → IDLE next cycle, new grant the cycle after.
- **Round-robin (macro defined):** all 4 valid continuously, `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0 at 3-cycle spacing.
- **Fixed priority (macro undefined):** same stimulus → `rsp_id` always 0; drop req 0 → `rsp_id` becomes 1.
